// File: rtl/systolic_controller_if.sv
// Command and buffer/array control bundle for the systolic array sequencer.
// The slave modport is the sequencer; the master modport is the surrounding
// command source, operand/result buffers and PE array.
interface systolic_controller_if #(
  parameter int N  = 2,
  parameter int KW = 8,
  parameter int AW = 8,
  parameter int SW = (N > 1) ? $clog2(N) : 1
);
  logic          start;
  logic [KW-1:0] k_len;
  logic [AW-1:0] a_base;
  logic [AW-1:0] b_base;
  logic [AW-1:0] res_base;
  logic          a_rd_en;
  logic [AW-1:0] a_rd_addr;
  logic          b_rd_en;
  logic [AW-1:0] b_rd_addr;
  logic [N-1:0]  row_valid;
  logic [N-1:0]  col_valid;
  logic          pe_clear;
  logic          res_wr_en;
  logic [SW-1:0] res_row_sel;
  logic [AW-1:0] res_wr_addr;
  logic          busy;
  logic          done;

  modport slave (
    input  start, k_len, a_base, b_base, res_base,
    output a_rd_en, a_rd_addr, b_rd_en, b_rd_addr, row_valid, col_valid,
           pe_clear, res_wr_en, res_row_sel, res_wr_addr, busy, done
  );

  modport master (
    output start, k_len, a_base, b_base, res_base,
    input  a_rd_en, a_rd_addr, b_rd_en, b_rd_addr, row_valid, col_valid,
           pe_clear, res_wr_en, res_row_sel, res_wr_addr, busy, done
  );
endinterface

// File: rtl/systolic_controller.sv
// Sequencer for an N x N output-stationary systolic array: clears the PE
// accumulators, streams K skewed operand slices, drains the wavefront,
// writes the N result rows and pulses done. All outputs are registered.
module systolic_controller #(
  parameter int N  = 2,
  parameter int KW = 8,
  parameter int AW = 8,
  parameter int SW = (N > 1) ? $clog2(N) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  systolic_controller_if.slave bus
);

  // Counter must reach K+N-2 with K up to 2^KW-1; KW+SW+1 bits covers K+2N.
  localparam int CW = KW + SW + 1;
  localparam logic [CW-1:0] N_LAST = CW'(N - 1);

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    FEED,
    DRAIN,
    WRITE,
    DONE
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic          latch;

  logic [KW-1:0] k_q;
  logic [AW-1:0] a_base_q;
  logic [AW-1:0] b_base_q;
  logic [AW-1:0] res_base_q;

  logic [CW-1:0] k_ext;
  logic [CW-1:0] feed_last;

  logic          a_rd_en_d;
  logic [AW-1:0] a_rd_addr_d;
  logic          b_rd_en_d;
  logic [AW-1:0] b_rd_addr_d;
  logic [N-1:0]  row_valid_d;
  logic [N-1:0]  col_valid_d;
  logic          pe_clear_d;
  logic          res_wr_en_d;
  logic [SW-1:0] res_row_sel_d;
  logic [AW-1:0] res_wr_addr_d;
  logic          busy_d;
  logic          done_d;

  assign k_ext     = CW'(k_q);
  // Only meaningful for K >= 1; the K == 0 path skips FEED entirely.
  assign feed_last = k_ext + N_LAST - CW'(1);

  // State and phase counter register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Command parameters captured on an accepted start.
  always_ff @(posedge clk) begin
    if (!reset) begin
      k_q        <= '0;
      a_base_q   <= '0;
      b_base_q   <= '0;
      res_base_q <= '0;
    end else if (latch) begin
      k_q        <= bus.k_len;
      a_base_q   <= bus.a_base;
      b_base_q   <= bus.b_base;
      res_base_q <= bus.res_base;
    end
  end

  // Next-state and counter sequencing through the phases.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    latch     = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          latch     = 1'b1;
          state_nxt = CLEAR;
          cnt_nxt   = '0;
        end
      end
      CLEAR: begin
        cnt_nxt   = '0;
        state_nxt = (k_q == '0) ? WRITE : FEED;
      end
      FEED: begin
        if (cnt == feed_last) begin
          state_nxt = DRAIN;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      DRAIN: begin
        if (cnt == N_LAST) begin
          state_nxt = WRITE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      WRITE: begin
        if (cnt == N_LAST) begin
          state_nxt = DONE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      DONE: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Output values for the upcoming cycle, decoded from next state/counter
  // so the registered outputs line up with the state they describe.
  always_comb begin
    a_rd_en_d     = 1'b0;
    a_rd_addr_d   = '0;
    b_rd_en_d     = 1'b0;
    b_rd_addr_d   = '0;
    row_valid_d   = '0;
    col_valid_d   = '0;
    pe_clear_d    = 1'b0;
    res_wr_en_d   = 1'b0;
    res_row_sel_d = '0;
    res_wr_addr_d = '0;
    done_d        = 1'b0;
    busy_d        = (state_nxt != IDLE);
    unique case (state_nxt)
      CLEAR: pe_clear_d = 1'b1;
      FEED: begin
        if (cnt_nxt < k_ext) begin
          a_rd_en_d   = 1'b1;
          b_rd_en_d   = 1'b1;
          a_rd_addr_d = a_base_q + AW'(cnt_nxt);
          b_rd_addr_d = b_base_q + AW'(cnt_nxt);
        end
        // Lane i sees slice t-i: valid once the skew has elapsed and
        // until its K slices have passed.
        for (int unsigned i = 0; i < N; i++) begin
          row_valid_d[i] = (cnt_nxt >= CW'(i)) && ((cnt_nxt - CW'(i)) < k_ext);
        end
        col_valid_d = row_valid_d;
      end
      WRITE: begin
        res_wr_en_d   = 1'b1;
        res_row_sel_d = SW'(cnt_nxt);
        res_wr_addr_d = res_base_q + AW'(cnt_nxt);
      end
      DONE: done_d = 1'b1;
      default: ;
    endcase
  end

  // Registered outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      bus.a_rd_en     <= 1'b0;
      bus.a_rd_addr   <= '0;
      bus.b_rd_en     <= 1'b0;
      bus.b_rd_addr   <= '0;
      bus.row_valid   <= '0;
      bus.col_valid   <= '0;
      bus.pe_clear    <= 1'b0;
      bus.res_wr_en   <= 1'b0;
      bus.res_row_sel <= '0;
      bus.res_wr_addr <= '0;
      bus.busy        <= 1'b0;
      bus.done        <= 1'b0;
    end else begin
      bus.a_rd_en     <= a_rd_en_d;
      bus.a_rd_addr   <= a_rd_addr_d;
      bus.b_rd_en     <= b_rd_en_d;
      bus.b_rd_addr   <= b_rd_addr_d;
      bus.row_valid   <= row_valid_d;
      bus.col_valid   <= col_valid_d;
      bus.pe_clear    <= pe_clear_d;
      bus.res_wr_en   <= res_wr_en_d;
      bus.res_row_sel <= res_row_sel_d;
      bus.res_wr_addr <= res_wr_addr_d;
      bus.busy        <= busy_d;
      bus.done        <= done_d;
    end
  end

endmodule

// File: tb/tb_systolic_controller.sv
// Bench for systolic_controller: per-cycle output trace against a timeline
// model, plus an environment model (buffers, skew, 2x2 PE array) whose
// written results are compared with a plain matrix product.
module tb_systolic_controller;
  localparam int N  = 2;
  localparam int KW = 8;
  localparam int AW = 8;
  localparam int SW = 1;

  typedef struct packed {
    logic          a_rd_en;
    logic [AW-1:0] a_rd_addr;
    logic          b_rd_en;
    logic [AW-1:0] b_rd_addr;
    logic [N-1:0]  row_valid;
    logic [N-1:0]  col_valid;
    logic          pe_clear;
    logic          res_wr_en;
    logic [SW-1:0] res_row_sel;
    logic [AW-1:0] res_wr_addr;
    logic          busy;
    logic          done;
  } outs_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  systolic_controller_if #(.N(N), .KW(KW), .AW(AW), .SW(SW)) bus();
  systolic_controller #(.N(N), .KW(KW), .AW(AW), .SW(SW)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  // Buffers: A word at a_base+k holds column k of A, B word at b_base+k row k of B.
  logic [15:0] a_mem   [256][N];
  logic [15:0] b_mem   [256][N];
  logic [31:0] res_mem [256][N];
  logic [31:0] acc     [N][N];
  logic [N-1:0]  h_rv [8];
  logic [N-1:0]  h_cv [8];
  logic [AW-1:0] h_aa [8];
  logic [AW-1:0] h_ba [8];
  int ncyc = 0;
  int wr_count = 0;
  int done_count = 0;

  // Environment: PE(i,j) meets the A and B words read i+j cycles earlier,
  // when row i was valid j cycles ago and column j valid i cycles ago.
  always @(negedge clk) begin
    logic [N-1:0]  rv;
    logic [N-1:0]  cv;
    logic [AW-1:0] aa;
    logic [AW-1:0] ba;
    ncyc <= ncyc + 1;
    h_rv[ncyc & 7] <= bus.row_valid;
    h_cv[ncyc & 7] <= bus.col_valid;
    h_aa[ncyc & 7] <= bus.a_rd_addr;
    h_ba[ncyc & 7] <= bus.b_rd_addr;
    if (bus.done) done_count <= done_count + 1;
    if (bus.res_wr_en) begin
      wr_count <= wr_count + 1;
      for (int j = 0; j < N; j++) res_mem[bus.res_wr_addr][j] <= acc[bus.res_row_sel][j];
    end
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        rv = (j == 0) ? bus.row_valid : h_rv[(ncyc - j) & 7];
        cv = (i == 0) ? bus.col_valid : h_cv[(ncyc - i) & 7];
        aa = (i + j == 0) ? bus.a_rd_addr : h_aa[(ncyc - i - j) & 7];
        ba = (i + j == 0) ? bus.b_rd_addr : h_ba[(ncyc - i - j) & 7];
        if (bus.pe_clear) acc[i][j] <= '0;
        else if (rv[i] && cv[j]) acc[i][j] <= acc[i][j] + 32'(a_mem[aa][i]) * 32'(b_mem[ba][j]);
      end
    end
  end

  function automatic outs_t snap();
    outs_t o;
    o.a_rd_en     = bus.a_rd_en;
    o.a_rd_addr   = bus.a_rd_addr;
    o.b_rd_en     = bus.b_rd_en;
    o.b_rd_addr   = bus.b_rd_addr;
    o.row_valid   = bus.row_valid;
    o.col_valid   = bus.col_valid;
    o.pe_clear    = bus.pe_clear;
    o.res_wr_en   = bus.res_wr_en;
    o.res_row_sel = bus.res_row_sel;
    o.res_wr_addr = bus.res_wr_addr;
    o.busy        = bus.busy;
    o.done        = bus.done;
    return o;
  endfunction

  // Edge count from accepted start to done.
  function automatic int latency(int k);
    return (k == 0) ? (2 + N) : (2 + (k + N - 1) + N + N);
  endfunction

  // Expected outputs d edges after the edge that accepted start.
  function automatic outs_t exp_out(int d, int k, logic [AW-1:0] ab, logic [AW-1:0] bb,
                                    logic [AW-1:0] rb);
    outs_t o = '0;
    int feed_len = (k == 0) ? 0 : k + N - 1;
    int w0 = 2 + feed_len + ((k == 0) ? 0 : N);
    int t;
    o.busy = (d >= 1) && (d <= w0 + N);
    if (d == 1) o.pe_clear = 1'b1;
    else if (d >= 2 && d < 2 + feed_len) begin
      t = d - 2;
      if (t < k) begin
        o.a_rd_en = 1'b1;
        o.b_rd_en = 1'b1;
        o.a_rd_addr = ab + AW'(t);
        o.b_rd_addr = bb + AW'(t);
      end
      for (int i = 0; i < N; i++) begin
        o.row_valid[i] = (t >= i) && (t - i < k);
        o.col_valid[i] = (t >= i) && (t - i < k);
      end
    end else if (d >= w0 && d < w0 + N) begin
      o.res_wr_en = 1'b1;
      o.res_row_sel = SW'(d - w0);
      o.res_wr_addr = rb + AW'(d - w0);
    end else if (d == w0 + N) o.done = 1'b1;
    return o;
  endfunction

  function automatic logic [31:0] mat_c(int r, int j, int k, logic [AW-1:0] ab, logic [AW-1:0] bb);
    logic [31:0] s = '0;
    logic [AW-1:0] ka;
    logic [AW-1:0] kb;
    for (int x = 0; x < k; x++) begin
      ka = ab + AW'(x);
      kb = bb + AW'(x);
      s = s + 32'(a_mem[ka][r]) * 32'(b_mem[kb][j]);
    end
    return s;
  endfunction

  task automatic fill_rand(int k, logic [AW-1:0] ab, logic [AW-1:0] bb);
    logic [AW-1:0] ad;
    for (int x = 0; x < k; x++) begin
      for (int i = 0; i < N; i++) begin
        ad = ab + AW'(x);
        a_mem[ad][i] = 16'($urandom);
        ad = bb + AW'(x);
        b_mem[ad][i] = 16'($urandom);
      end
    end
  endtask

  task automatic issue(int k, logic [AW-1:0] ab, logic [AW-1:0] bb, logic [AW-1:0] rb);
    bus.k_len = KW'(k);
    bus.a_base = ab;
    bus.b_base = bb;
    bus.res_base = rb;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    outs_t got;
    reset = 1'b0;
    bus.start = 1'b1;
    bus.k_len = 8'd3;
    bus.a_base = '0;
    bus.b_base = '0;
    bus.res_base = '0;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      got = snap();
      checks++;
      if (got !== outs_t'('0)) begin
        errors++;
        $display("FAIL reset_hold cyc=%0d got=%h exp=0", c, got);
      end
    end
    bus.start = 1'b0;
    reset = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      got = snap();
      checks++;
      if (got !== outs_t'('0)) begin
        errors++;
        $display("FAIL reset_release cyc=%0d got=%h exp=0", c, got);
      end
    end
  endtask

  task automatic test_basic_datapath();
    outs_t got, exp;
    int lat = latency(2);
    int w0 = wr_count;
    int d0 = done_count;
    logic [31:0] want [N][N] = '{'{32'd19, 32'd22}, '{32'd43, 32'd50}};
    a_mem[8'h10] = '{16'd1, 16'd3};
    a_mem[8'h11] = '{16'd2, 16'd4};
    b_mem[8'h20] = '{16'd5, 16'd6};
    b_mem[8'h21] = '{16'd7, 16'd8};
    issue(2, 8'h10, 8'h20, 8'h40);
    for (int d = 1; d <= lat + 1; d++) begin
      got = snap();
      exp = exp_out(d, 2, 8'h10, 8'h20, 8'h40);
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL basic_trace d=%0d got=%h exp=%h", d, got, exp);
      end
      @(posedge clk); #1;
    end
    for (int r = 0; r < N; r++) begin
      for (int j = 0; j < N; j++) begin
        checks++;
        if (res_mem[8'h40 + r][j] !== want[r][j]) begin
          errors++;
          $display("FAIL datapath_c r=%0d j=%0d got=%0d exp=%0d", r, j, res_mem[8'h40 + r][j], want[r][j]);
        end
      end
    end
    checks++;
    if (wr_count - w0 != N || done_count - d0 != 1) begin
      errors++;
      $display("FAIL basic_counts writes=%0d dones=%0d exp %0d/1", wr_count - w0, done_count - d0, N);
    end
  endtask

  task automatic test_k0();
    outs_t got, exp;
    int lat = latency(0);
    issue(0, 8'h10, 8'h20, 8'h40);
    for (int d = 1; d <= lat + 1; d++) begin
      got = snap();
      exp = exp_out(d, 0, 8'h10, 8'h20, 8'h40);
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL k0_trace d=%0d got=%h exp=%h", d, got, exp);
      end
      @(posedge clk); #1;
    end
    for (int r = 0; r < N; r++) begin
      for (int j = 0; j < N; j++) begin
        checks++;
        if (res_mem[8'h40 + r][j] !== 32'd0) begin
          errors++;
          $display("FAIL k0_zero r=%0d j=%0d got=%0d exp=0", r, j, res_mem[8'h40 + r][j]);
        end
      end
    end
  endtask

  task automatic test_wrap_ignored_start();
    outs_t got, exp;
    int lat = latency(1);
    int d0 = done_count;
    logic [AW-1:0] ra;
    fill_rand(1, 8'h33, 8'hFE);
    issue(1, 8'h33, 8'hFE, 8'hFF);
    for (int d = 1; d <= lat + 1; d++) begin
      got = snap();
      exp = exp_out(d, 1, 8'h33, 8'hFE, 8'hFF);
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL wrap_trace d=%0d got=%h exp=%h", d, got, exp);
      end
      bus.start = (d == 2) || (d == lat);
      bus.k_len = 8'd7;
      @(posedge clk); #1;
    end
    bus.start = 1'b0;
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (bus.busy !== 1'b0) begin
        errors++;
        $display("FAIL wrap_no_restart cyc=%0d busy=%b exp=0", c, bus.busy);
      end
      @(posedge clk); #1;
    end
    checks++;
    if (done_count - d0 != 1) begin
      errors++;
      $display("FAIL wrap_single_done dones=%0d exp=1", done_count - d0);
    end
    for (int r = 0; r < N; r++) begin
      for (int j = 0; j < N; j++) begin
        ra = 8'hFF + AW'(r);
        checks++;
        if (res_mem[ra][j] !== mat_c(r, j, 1, 8'h33, 8'hFE)) begin
          errors++;
          $display("FAIL wrap_c r=%0d j=%0d got=%0d exp=%0d", r, j, res_mem[ra][j], mat_c(r, j, 1, 8'h33, 8'hFE));
        end
      end
    end
  endtask

  task automatic run_checked(string tag, int k, logic [AW-1:0] ab, logic [AW-1:0] bb,
                             logic [AW-1:0] rb, bit poke);
    outs_t got, exp;
    int lat = latency(k);
    int w0 = wr_count;
    int d0 = done_count;
    logic [AW-1:0] ra;
    fill_rand(k, ab, bb);
    issue(k, ab, bb, rb);
    for (int d = 1; d <= lat + 1; d++) begin
      got = snap();
      exp = exp_out(d, k, ab, bb, rb);
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL %s_trace k=%0d d=%0d got=%h exp=%h", tag, k, d, got, exp);
      end
      bus.start = poke && (d <= lat) && ($urandom_range(3) == 0);
      @(posedge clk); #1;
    end
    bus.start = 1'b0;
    for (int r = 0; r < N; r++) begin
      for (int j = 0; j < N; j++) begin
        ra = rb + AW'(r);
        checks++;
        if (res_mem[ra][j] !== mat_c(r, j, k, ab, bb)) begin
          errors++;
          $display("FAIL %s_c k=%0d r=%0d j=%0d got=%0d exp=%0d", tag, k, r, j, res_mem[ra][j], mat_c(r, j, k, ab, bb));
        end
      end
    end
    checks++;
    if (wr_count - w0 != N || done_count - d0 != 1) begin
      errors++;
      $display("FAIL %s_counts writes=%0d dones=%0d exp %0d/1", tag, wr_count - w0, done_count - d0, N);
    end
  endtask

  task automatic test_reset_mid_feed();
    outs_t got, exp;
    int w0 = wr_count;
    int d0 = done_count;
    issue(5, 8'h01, 8'h02, 8'h03);
    for (int d = 1; d <= 3; d++) begin
      got = snap();
      exp = exp_out(d, 5, 8'h01, 8'h02, 8'h03);
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL midrst_pre d=%0d got=%h exp=%h", d, got, exp);
      end
      if (d < 3) begin
        @(posedge clk); #1;
      end
    end
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    for (int c = 0; c < 12; c++) begin
      got = snap();
      checks++;
      if (got !== outs_t'('0)) begin
        errors++;
        $display("FAIL midrst_idle cyc=%0d got=%h exp=0", c, got);
      end
      @(posedge clk); #1;
    end
    checks++;
    if (wr_count != w0 || done_count != d0) begin
      errors++;
      $display("FAIL midrst_no_complete writes=%0d dones=%0d exp 0/0", wr_count - w0, done_count - d0);
    end
    run_checked("midrst_fresh", 3, 8'h50, 8'h60, 8'h70, 1'b0);
  endtask

  task automatic test_random();
    for (int it = 0; it < 10; it++) begin
      run_checked("rand", $urandom_range(9), AW'($urandom), AW'($urandom), AW'($urandom), 1'b1);
      repeat ($urandom_range(2)) begin
        @(posedge clk); #1;
      end
    end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.k_len = '0;
    bus.a_base = '0;
    bus.b_base = '0;
    bus.res_base = '0;
    for (int x = 0; x < 256; x++) begin
      for (int i = 0; i < N; i++) begin
        a_mem[x][i] = '0;
        b_mem[x][i] = '0;
      end
    end
    test_reset();
    test_basic_datapath();
    test_k0();
    test_wrap_ignored_start();
    test_reset_mid_feed();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "bench timeout");
  end

endmodule

// File: doc/systolic_controller.md
Name: systolic_controller

Overview:
Sequencer for the N x N output-stationary systolic array of processing elements (16-bit a/b operands, 32-bit accumulation). On a start pulse it clears PE accumulators, streams K operand columns/rows from the operand buffers with per-row/per-column skewed valids, waits for the wavefront to drain, then writes the N result rows to the result buffer and pulses done. It sits between the top-level command interface and the array, skew registers and buffers.

Parameters:
N, 2, array dimension (rows = columns = N), N >= 1
KW, 8, width of inner-dimension length k_len
AW, 8, buffer address width
SW, $clog2(N) (min 1), width of res_row_sel

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-low reset (asserted when 0)
start  input  1  single-cycle command; accepted only in IDLE
k_len  input  KW  inner dimension K; latched on accepted start
a_base  input  AW  A-buffer base address; latched on start
b_base  input  AW  B-buffer base address; latched on start
res_base  input  AW  result-buffer base address; latched on start
a_rd_en  output  1  A-buffer read enable
a_rd_addr  output  AW  A-buffer read address
b_rd_en  output  1  B-buffer read enable
b_rd_addr  output  AW  B-buffer read address
row_valid  output  N  bit i: array row i receives a valid a operand this cycle
col_valid  output  N  bit j: array column j receives a valid b operand this cycle
pe_clear  output  1  zero all PE accumulators
res_wr_en  output  1  result-buffer write enable
res_row_sel  output  SW  array result row driven onto result bus
res_wr_addr  output  AW  result-buffer write address
busy  output  1  high in every state except IDLE
done  output  1  one-cycle completion pulse

Behaviour:
- Reset (reset==0 at rising edge): state IDLE, counter 0, all outputs 0, latched k_len/bases cleared. Applies mid-operation; no write or done completes after it.
- States: IDLE -> CLEAR -> FEED -> DRAIN -> WRITE -> DONE -> IDLE. All outputs registered (Moore).
- IDLE: busy=0. start=1 -> latch inputs, go CLEAR. start in any other state ignored.
- CLEAR: 1 cycle, pe_clear=1. Next FEED, or WRITE if latched K==0 (writes the cleared zeros).
- FEED: counter t = 0 .. K+N-2 (K+N-1 cycles).
  - a_rd_en=b_rd_en=(t<K); a_rd_addr=a_base+t, b_rd_addr=b_base+t when enabled, else hold 0.
  - row_valid[i] = col_valid[i] = (t>=i) && (t-i<K).
  - Address adds are modulo 2^AW (wrap, no error).
- DRAIN: N cycles, all enables/valids 0, allowing last PE (N-1,N-1) to complete its final MAC and register it.
- WRITE: N cycles, r = 0..N-1: res_wr_en=1, res_row_sel=r, res_wr_addr=res_base+r (mod 2^AW).
- DONE: 1 cycle, done=1, busy=1; next IDLE. start on the DONE cycle is ignored; start on the following cycle is accepted.
- Total latency start-accepted to done: 1+(K+N-1)+N+N+1 cycles for K>=1; 1+N+1 for K=0.
- Counter width sized for K+2N; no overflow for any K up to 2^KW-1.

Test Plan:
- Reset: hold reset=0 for 2 cycles -> all outputs 0, busy=0; start while reset=0 has no effect.
- N=2, K=2, a_base=0x10, b_base=0x20, res_base=0x40, start pulse -> pe_clear 1 cycle; FEED 3 cycles: a_rd_addr 0x10,0x11 with rd_en 1,1,0; row_valid 01,11,10; DRAIN 2 cycles; writes addr 0x40 row 0, 0x41 row 1; done 9 cycles after start.
- Full datapath with 2x2 PE array: A=[[1,2],[3,4]], B=[[5,6],[7,8]] -> written rows [19,22] and [43,50].
- K=0 start -> CLEAR, then 2 writes (0x40,0x41) of zero results, done 4 cycles after start, no rd_en ever asserted.
- Wrap/ignored start: res_base=0xFF, K=1 -> res_wr_addr 0xFF then 0x00; start re-pulsed during FEED and DONE ignored (single done, no restart).
- Reset mid-FEED -> next cycle IDLE, all outputs 0, no res_wr_en/done; fresh start then runs normally.
